pulse_train_gen: RTL and testbench

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

---
 rtl/pulse_train_pkg.sv | 14 +
 rtl/pulse_train_gen_phase_cnt.sv | 29 ++
 rtl/pulse_train_gen.sv | 151 +++++++++++++++
 tb/tb_pulse_train_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pulse_train_pkg.sv
// Shared types and default widths for the pulse train generator.
package pulse_train_pkg;

    localparam int LEN_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pulse_train_gen_phase_cnt.sv
// Reloadable phase down-counter: holds the cycles remaining in the current phase.
module pulse_phase_cnt
    import pulse_train_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LEN_W-1:0] value,
    output logic             zero
);

    logic [LEN_W-1:0] cnt_q;

    // Stops at zero so it can never wrap between phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: N pulses of H high / L low cycles, then a done strobe.
// Optional abort input compiled in with macro PULSE_TRAIN_ABORT_EN.
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [LEN_W-1:0] high_len_i,
    input  logic [LEN_W-1:0] low_len_i,
`ifdef PULSE_TRAIN_ABORT_EN
    input  logic             abort_i,
`endif
    output logic             pulse_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [LEN_W-1:0] hi_m1_q;
    logic [LEN_W-1:0] lo_m1_q;
    logic             abort;
    logic             launch;
    logic             ph_load;
    logic [LEN_W-1:0] ph_value;
    logic             ph_zero;

`ifdef PULSE_TRAIN_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    // Phase counter holds "cycles left minus one", so a length of 0 or 1 both load 0.
    function automatic logic [LEN_W-1:0] len_m1(input logic [LEN_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    assign launch = start_i && !abort;

    always_comb begin
        ph_load  = 1'b0;
        ph_value = hi_m1_q;
        case (state_q)
            ST_IDLE: begin
                if (launch && count_i != '0) begin
                    ph_load  = 1'b1;
                    ph_value = len_m1(high_len_i);
                end
            end
            ST_HIGH: begin
                if (ph_zero) begin
                    ph_load  = 1'b1;
                    ph_value = lo_m1_q;
                end
            end
            ST_LOW: begin
                if (ph_zero && cnt_q != CNT_W'(1)) begin
                    ph_load  = 1'b1;
                    ph_value = hi_m1_q;
                end
            end
            default: ;
        endcase
    end

    pulse_phase_cnt #(
        .LEN_W (LEN_W)
    ) u_phase_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ph_load),
        .value (ph_value),
        .zero  (ph_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_m1_q <= '0;
            lo_m1_q <= '0;
            pulse_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    if (launch) begin
                        hi_m1_q <= len_m1(high_len_i);
                        lo_m1_q <= len_m1(low_len_i);
                        cnt_q   <= count_i;
                        if (count_i == '0) begin
                            state_q <= ST_DONE;
                            done_o  <= 1'b1;
                        end else begin
                            state_q <= ST_HIGH;
                            pulse_o <= 1'b1;
                            busy_o  <= 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        pulse_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end else if (ph_zero) begin
                        state_q <= ST_LOW;
                        pulse_o <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end else if (ph_zero) begin
                        // cnt_q counts pulses still to finish, including the current one.
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_DONE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_HIGH;
                            pulse_o <= 1'b1;
                            cnt_q   <= cnt_q - 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done_o  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    pulse_o <= 1'b0;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen against a cycle-index waveform model.
module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] count_i = '0;
    logic [7:0] high_len_i = '0;
    logic [7:0] low_len_i = '0;
    logic       pulse_o;
    logic       busy_o;
    logic       done_o;
`ifdef PULSE_TRAIN_ABORT_EN
    logic       abort_i = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    pulse_train_gen #(.LEN_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .count_i    (count_i),
        .high_len_i (high_len_i),
        .low_len_i  (low_len_i),
`ifdef PULSE_TRAIN_ABORT_EN
        .abort_i    (abort_i),
`endif
        .pulse_o    (pulse_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ep, input logic eb, input logic ed);
        chk({tag, " pulse"}, pulse_o, ep);
        chk({tag, " busy"}, busy_o, eb);
        chk({tag, " done"}, done_o, ed);
    endtask

    // Expected outputs k cycles after the start edge, from the timing rules.
    task automatic model(input int n, input int h, input int l, input int k,
                         output logic ep, output logic eb, output logic ed);
        int he, le, p, idx;
        he  = (h == 0) ? 1 : h;
        le  = (l == 0) ? 1 : l;
        p   = he + le;
        idx = k - 1;
        eb  = (idx < n * p);
        ep  = eb && ((idx % p) < he);
        ed  = (idx == n * p);
    endtask

    task automatic launch(input int n, input int h, input int l);
        @(negedge clk);
        count_i    = 8'(n);
        high_len_i = 8'(h);
        low_len_i  = 8'(l);
        start_i    = 1'b1;
    endtask

    // Runs one train to completion; with disturb, start and inputs toggle while busy/done.
    task automatic run_train(input int n, input int h, input int l, input bit disturb,
                             input string name);
        int he, le, total;
        logic ep, eb, ed;
        he    = (h == 0) ? 1 : h;
        le    = (l == 0) ? 1 : l;
        total = n * (he + le) + 1;
        launch(n, h, l);
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            model(n, h, l, k, ep, eb, ed);
            chk_out($sformatf("%s k=%0d", name, k), ep, eb, ed);
            if (disturb) begin
                start_i    = ($urandom_range(0, 1) == 1) || (k == 2);
                count_i    = 8'($urandom_range(0, 5));
                high_len_i = 8'($urandom_range(0, 5));
                low_len_i  = 8'($urandom_range(0, 5));
            end
        end
        start_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk_out($sformatf("%s idle%0d", name, k), 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic ep, eb, ed;
        int n, h, l;

        // Reset state
        repeat (2) @(negedge clk);
        chk_out("reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_out("post_reset", 1'b0, 1'b0, 1'b0);

        run_train(3, 2, 1, 1'b0, "n3h2l1");
        run_train(0, 3, 3, 1'b0, "count0");
        run_train(1, 0, 0, 1'b0, "zero_len");
        run_train(3, 2, 1, 1'b1, "ignore_start");

        // Asynchronous reset in the middle of a train
        launch(3, 2, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            model(3, 2, 1, k, ep, eb, ed);
            chk_out($sformatf("pre_rst k=%0d", k), ep, eb, ed);
        end
        #1 rst_n = 1'b0;
        #1 chk_out("async_rst", 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_out($sformatf("in_rst%0d", k), 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk_out("rst_release", 1'b0, 1'b0, 1'b0);
        run_train(2, 1, 3, 1'b0, "after_rst");

`ifdef PULSE_TRAIN_ABORT_EN
        launch(4, 3, 1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            chk_out($sformatf("pre_abort k=%0d", k), 1'b1, 1'b1, 1'b0);
        end
        abort_i = 1'b1;
        for (int k = 3; k <= 20; k++) begin
            @(negedge clk);
            abort_i = 1'b0;
            chk_out($sformatf("aborted k=%0d", k), 1'b0, 1'b0, 1'b0);
        end
        launch(2, 2, 2);
        abort_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            abort_i = 1'b0;
            chk_out($sformatf("abort_start k=%0d", k), 1'b0, 1'b0, 1'b0);
        end
        run_train(1, 2, 2, 1'b0, "after_abort");
`endif

        for (int i = 0; i < 10; i++) begin
            n = $urandom_range(0, 4);
            h = $urandom_range(0, 4);
            l = $urandom_range(0, 4);
            run_train(n, h, l, bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
